// File: rtl/station_pkg.sv
// Shared station definitions: reading FSM encoding, default temperature
// thresholds and the threshold classifier used by the sampler.
package station_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACCUM  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [11:0] DEF_HOT_THRESH  = 12'hA00;
   localparam logic [11:0] DEF_COLD_THRESH = 12'h600;

   // Returns {hot, cold}; callers guarantee hot_t > cold_t so both never set.
   function automatic logic [1:0] classify(input logic [11:0] avg,
                                           input logic [11:0] hot_t,
                                           input logic [11:0] cold_t);
      return {(avg >= hot_t), (avg <= cold_t)};
   endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// Request/sample/result signals between station logic, the XADC sample
// stream and the temperature sampler.
interface temp_sampler_if;
   logic        start;
   logic [11:0] digitalTemp;
   logic        ready;
   logic [11:0] tempAvg;
   logic        isHot;
   logic        isCold;
   logic        done;
   logic        busy;
   logic        timeout;

   modport master (
      output start, digitalTemp, ready,
      input  tempAvg, isHot, isCold, done, busy, timeout
   );

   modport slave (
      input  start, digitalTemp, ready,
      output tempAvg, isHot, isCold, done, busy, timeout
   );
endinterface

// File: rtl/temp_sampler.sv
// Averages 2^NUM_LOG2 XADC samples after a settle delay, classifies the
// result as hot/cold, and aborts with timeout if samples stop arriving.
module temp_sampler
   import station_pkg::*;
#(
   parameter int unsigned NUM_LOG2       = 3,
   parameter int unsigned SETTLE_CYCLES  = 100,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter logic [11:0] HOT_THRESH     = DEF_HOT_THRESH,
   parameter logic [11:0] COLD_THRESH    = DEF_COLD_THRESH
) (
   input  logic          CLK,
   input  logic          RSTn,
   temp_sampler_if.slave bus
);

   localparam int unsigned ACC_W = 12 + NUM_LOG2;
   localparam int unsigned CNT_W = NUM_LOG2 + 1;
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   samp_cnt_q;
   logic [SET_W-1:0]   settle_cnt_q;
   logic [TO_W-1:0]    idle_cnt_q;
   logic [11:0]        avg_q;
   logic               hot_q, cold_q, to_q;
   logic               busy_c, done_c;

   logic               sample_ok, last_sample, settle_end, idle_expire;
   logic [ACC_W-1:0]   acc_sum;
   logic [11:0]        avg_new;
   logic [1:0]         cls_new;

   assign sample_ok   = (state_q == ST_ACCUM) && bus.ready;
   assign last_sample = sample_ok && (samp_cnt_q == CNT_W'((1 << NUM_LOG2) - 1));
   assign settle_end  = (state_q == ST_SETTLE) &&
                        (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));
   assign idle_expire = (state_q == ST_ACCUM) && !bus.ready &&
                        (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // The final sample is folded in combinationally so the average is
   // already registered when the FSM enters DONE.
   assign acc_sum = acc_q + ACC_W'(bus.digitalTemp);
   assign avg_new = acc_sum[ACC_W-1:NUM_LOG2];
   assign cls_new = classify(avg_new, HOT_THRESH, COLD_THRESH);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (bus.start) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_end) state_d = ST_ACCUM;
         ST_ACCUM:  if (last_sample || idle_expire) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);
      done_c = (state_q == ST_DONE);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         acc_q        <= '0;
         samp_cnt_q   <= '0;
         settle_cnt_q <= '0;
         idle_cnt_q   <= '0;
         avg_q        <= '0;
         hot_q        <= 1'b0;
         cold_q       <= 1'b0;
         to_q         <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  acc_q        <= '0;
                  samp_cnt_q   <= '0;
                  settle_cnt_q <= '0;
                  idle_cnt_q   <= '0;
                  to_q         <= 1'b0;
               end
            end
            ST_SETTLE: settle_cnt_q <= settle_cnt_q + SET_W'(1);
            ST_ACCUM: begin
               if (bus.ready) begin
                  acc_q      <= acc_sum;
                  samp_cnt_q <= samp_cnt_q + CNT_W'(1);
                  idle_cnt_q <= '0;
                  if (last_sample) begin
                     avg_q  <= avg_new;
                     hot_q  <= cls_new[1];
                     cold_q <= cls_new[0];
                  end
               end else begin
                  idle_cnt_q <= idle_cnt_q + TO_W'(1);
                  if (idle_expire) begin
                     to_q   <= 1'b1;
                     hot_q  <= 1'b0;
                     cold_q <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.tempAvg = avg_q;
   assign bus.isHot   = hot_q;
   assign bus.isCold  = cold_q;
   assign bus.timeout = to_q;
   assign bus.busy    = busy_c;
   assign bus.done    = done_c;

endmodule

// File: tb/tb_temp_sampler.sv
// Self-checking bench for temp_sampler: fixed vectors, randomized readings
// against an arithmetic reference, timeout and mid-reading reset sequences.
module tb_temp_sampler;

   localparam int S = 12;
   localparam int T = 40;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;
   int   cyc;
   int   done_at;
   int   done_cnt;
   logic [11:0] last_avg;

   temp_sampler_if bus ();

   temp_sampler #(
      .NUM_LOG2      (3),
      .SETTLE_CYCLES (S),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .CLK (clk),
      .RSTn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0][11:0] smp;
      logic [11:0]      avg;
      logic             hot;
      logic             cold;
   } vec_t;

   vec_t tbl [8];

   function automatic vec_t mk(input logic [95:0] s, input logic [11:0] a,
                               input logic h, input logic c);
      vec_t v;
      v.smp  = s;
      v.avg  = a;
      v.hot  = h;
      v.cold = c;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (done_at < 0) done_at = cyc;
      end
   endtask

   task automatic drive(input logic s, input logic r, input logic [11:0] d);
      bus.start       = s;
      bus.ready       = r;
      bus.digitalTemp = d;
   endtask

   // Cycle 0 carries start (with a stray ready), cycles 1..S are settle with
   // noise, accumulation follows; done is expected one cycle after the final
   // accepted sample, or T idle cycles after the last sample on timeout.
   task automatic do_reading(input logic [7:0][11:0] smp, input int nsamp,
                             input logic [11:0] ea, input logic eh,
                             input logic ec, input logic et, input string tag);
      int j;
      int g;
      int exp_done;
      cyc = 0;
      done_at = -1;
      done_cnt = 0;
      drive(1'b1, 1'b1, 12'(($urandom)));
      step();
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      for (int k = 1; k <= S; k++) begin
         drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 12'($urandom));
         step();
      end
      j = 0;
      for (int i = 0; i < nsamp; i++) begin
         g = $urandom_range(0, 4);
         for (int k = 0; k < g; k++) begin
            drive($urandom_range(0, 3) == 0, 1'b0, 12'($urandom));
            step();
         end
         drive($urandom_range(0, 3) == 0, 1'b1, smp[i]);
         step();
         j += g + 1;
      end
      exp_done = (nsamp == 8) ? S + j + 1 : S + j + T + 1;
      while (cyc < exp_done + 2) begin
         drive(cyc == exp_done, 1'b0, 12'($urandom));
         step();
      end
      drive(1'b0, 1'b0, 12'h000);
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_avg"}, 32'(bus.tempAvg), 32'(ea));
      chk({tag, "_hot"}, 32'(bus.isHot), 32'(eh));
      chk({tag, "_cold"}, 32'(bus.isCold), 32'(ec));
      chk({tag, "_timeout"}, 32'(bus.timeout), 32'(et));
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      if (!et) last_avg = ea;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0][11:0] rs;
      int          sum;
      logic [11:0] ravg;

      checks = 0;
      failures = 0;
      last_avg = 12'h000;
      rstn = 1'b0;
      drive(1'b0, 1'b0, 12'h000);

      tbl[0] = mk({8{12'h800}}, 12'h800, 1'b0, 1'b0);
      tbl[1] = mk({8{12'hC00}}, 12'hC00, 1'b1, 1'b0);
      tbl[2] = mk({8{12'h400}}, 12'h400, 1'b0, 1'b1);
      tbl[3] = mk({{4{12'hFFF}}, {4{12'h000}}}, 12'h7FF, 1'b0, 1'b0);
      tbl[4] = mk({8{12'hA00}}, 12'hA00, 1'b1, 1'b0);
      tbl[5] = mk({8{12'h9FF}}, 12'h9FF, 1'b0, 1'b0);
      tbl[6] = mk({8{12'h600}}, 12'h600, 1'b0, 1'b1);
      tbl[7] = mk({{4{12'h602}}, {4{12'h601}}}, 12'h601, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_avg", 32'(bus.tempAvg), 32'd0);
      chk("rst_hot", 32'(bus.isHot), 32'd0);
      chk("rst_cold", 32'(bus.isCold), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_timeout", 32'(bus.timeout), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 8; v++)
         do_reading(tbl[v].smp, 8, tbl[v].avg, tbl[v].hot, tbl[v].cold, 1'b0,
                    $sformatf("vec%0d", v));

      for (int r = 0; r < 10; r++) begin
         sum = 0;
         for (int i = 0; i < 8; i++) begin
            rs[i] = (r < 5) ? 12'($urandom) : 12'($urandom_range(12'h580, 12'hA80));
            sum += int'(rs[i]);
         end
         ravg = 12'(sum / 8);
         do_reading(rs, 8, ravg, ravg >= 12'hA00, ravg <= 12'h600, 1'b0,
                    $sformatf("rnd%0d", r));
      end

      rs = {8{12'hFFF}};
      do_reading(rs, 3, last_avg, 1'b0, 1'b0, 1'b1, "tmo");
      do_reading(tbl[0].smp, 8, tbl[0].avg, 1'b0, 1'b0, 1'b0, "after_tmo");

      // Reset lands mid-accumulation, after four accepted samples.
      cyc = 0;
      done_at = -1;
      done_cnt = 0;
      drive(1'b1, 1'b0, 12'h000);
      step();
      for (int k = 1; k <= S; k++) begin
         drive(1'b0, 1'b0, 12'h000);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 12'hC00);
         step();
      end
      drive(1'b0, 1'b0, 12'h000);
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_avg", 32'(bus.tempAvg), 32'd0);
      chk("midrst_hot", 32'(bus.isHot), 32'd0);
      chk("midrst_cold", 32'(bus.isCold), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_timeout", 32'(bus.timeout), 32'd0);
      repeat (3) step();
      #2;
      rstn = 1'b1;
      repeat (T + 4) step();
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      last_avg = 12'h000;
      do_reading(tbl[2].smp, 8, tbl[2].avg, tbl[2].hot, tbl[2].cold, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/temp_sampler.md
TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 SHALL have parameter NUM_LOG2, default 3, meaning log2 of samples averaged per reading (8 samples).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 100, meaning CLK cycles to wait after start before accepting samples.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning maximum CLK cycles allowed between accepted samples.
REQ-004 SHALL have parameter HOT_THRESH, default 12'hA00, meaning avg >= value classifies as hot.
REQ-005 SHALL have parameter COLD_THRESH, default 12'h600, meaning avg <= value classifies as cold.
REQ-006 SHALL have ports: CLK in 1, system clock; RSTn in 1, reset.
REQ-007 Reset SHALL be asynchronous, active-low; single clock domain CLK.
REQ-008 SHALL have ports: start in 1, one-cycle request from station logic; digitalTemp in 12, XADC sample; ready in 1, XADC sample-valid pulse.
REQ-009 SHALL have outputs: tempAvg out 12, averaged sample; isHot out 1; isCold out 1; done out 1, one-cycle completion pulse; busy out 1, reading in progress; timeout out 1, last reading aborted.

Function
REQ-010 FSM states SHALL be IDLE, SETTLE, ACCUM, DONE.
REQ-011 IDLE: busy=0; start=1 -> SETTLE, clears accumulator, sample counter, settle counter, and the timeout flag.
REQ-012 SETTLE: busy=1; ready pulses ignored; after exactly SETTLE_CYCLES cycles in SETTLE -> ACCUM.
REQ-013 ACCUM: busy=1; each cycle with ready=1 adds zero-extended digitalTemp to accumulator and increments sample counter.
REQ-014 Accumulator SHALL be 12+NUM_LOG2 bits wide; overflow impossible by construction.
REQ-015 When the 2^NUM_LOG2-th sample is accepted -> DONE next cycle; tempAvg = accumulator >> NUM_LOG2 (truncating).
REQ-016 Idle counter in ACCUM SHALL reset on every accepted sample; reaching TIMEOUT_CYCLES -> DONE with timeout=1, tempAvg unchanged, isHot=isCold=0.
REQ-017 DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
REQ-018 Classification in DONE (non-timeout): isHot = tempAvg >= HOT_THRESH; isCold = tempAvg <= COLD_THRESH; both 0 otherwise; never both 1 (HOT_THRESH > COLD_THRESH required).
REQ-019 tempAvg, isHot, isCold, timeout SHALL hold until the next DONE or reset.
REQ-020 start while busy=1 or in DONE SHALL be ignored.
REQ-021 Latency start -> done SHALL be 1 + SETTLE_CYCLES + (cycles to 8th ready) + 1.
REQ-022 ready coincident with start SHALL be ignored.

Reset
REQ-023 On RSTn=0: state IDLE; tempAvg=0, isHot=0, isCold=0, done=0, busy=0, timeout=0; all counters and accumulator 0.
REQ-024 Reset asserted mid-reading SHALL abort it with no done pulse.

Structure
REQ-025 State encodings and default thresholds SHALL live in shared package station_pkg, reused by the material system.
REQ-026 Single flat module; no sub-modules required.

Verification
REQ-027 start, eight ready with 12'h800 after settle -> done once, tempAvg=12'h800, isHot=0, isCold=0.
REQ-028 Eight samples 12'hC00 -> tempAvg=12'hC00, isHot=1; eight samples 12'h400 -> isCold=1.
REQ-029 Four 12'h000 plus four 12'hFFF -> tempAvg=12'h7FF (truncation).
REQ-030 ready pulses during SETTLE and with start -> discarded; average uses only post-settle samples.
REQ-031 Three samples then no ready for TIMEOUT_CYCLES -> done, timeout=1, isHot=isCold=0; second start mid-reading ignored.
REQ-032 RSTn low after four samples -> all outputs 0, no done; fresh start completes normally.
